// File: rtl/comp_pkg.sv
// Shared types for the serial comparator family: FSM states and the
// latched A-vs-B relation.
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REL_EQ = 2'b00,
        REL_GT = 2'b01,
        REL_LT = 2'b10
    } rel_t;

endpackage

// File: rtl/comp_1bit.sv
// Single-bit magnitude compare cell; exactly one of gt/lt/eq is high.
module comp_1bit (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic lt,
    output logic eq
);

    assign gt = a & ~b;
    assign lt = ~a & b;
    assign eq = ~(a ^ b);

endmodule

// File: rtl/comp_serial_msb.sv
// Bit-serial MSB-first magnitude comparator producing agb/alb/aeb once per word.
// Optional COMP_SERIAL_EARLY_EXIT_EN: finish on the first differing bit-pair.
module comp_serial_msb
    import comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_vld,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic agb,
    output logic alb,
    output logic aeb
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    rel_t          rel;
    rel_t          rel_nxt;
    logic          bit_gt;
    logic          bit_lt;
    logic          bit_eq;
    logic          accept;
    logic          finish;

    comp_1bit u_bit (
        .a  (a_bit),
        .b  (b_bit),
        .gt (bit_gt),
        .lt (bit_lt),
        .eq (bit_eq)
    );

    // start wins over a same-cycle bit, so that bit is never accepted
    assign accept = (state == CMP) && bit_vld && !start;
    assign busy   = (state == CMP);

    // Relation only moves away from EQ; once decided it is frozen
    always_comb begin
        rel_nxt = rel;
        if (rel == REL_EQ) begin
            unique case ({bit_gt, bit_lt, bit_eq})
                3'b100:  rel_nxt = REL_GT;
                3'b010:  rel_nxt = REL_LT;
                default: rel_nxt = rel;
            endcase
        end
    end

`ifdef COMP_SERIAL_EARLY_EXIT_EN
    assign finish = accept && ((cnt == LAST) || (rel_nxt != rel));
`else
    assign finish = accept && (cnt == LAST);
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CMP;
            CMP:     if (start) state_nxt = CMP;
                     else if (finish) state_nxt = DONE;
            DONE:    if (start) state_nxt = CMP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rel   <= REL_EQ;
            done  <= 1'b0;
            agb   <= 1'b0;
            alb   <= 1'b0;
            aeb   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= finish;
            if (start) begin
                cnt <= '0;
                rel <= REL_EQ;
                agb <= 1'b0;
                alb <= 1'b0;
                aeb <= 1'b0;
            end else if (accept) begin
                cnt <= cnt + CW'(1);
                rel <= rel_nxt;
                if (finish) begin
                    agb <= (rel_nxt == REL_GT);
                    alb <= (rel_nxt == REL_LT);
                    aeb <= (rel_nxt == REL_EQ);
                end
            end
        end
    end

endmodule

// File: tb/tb_comp_serial_msb.sv
// Scoreboard bench for comp_serial_msb (WIDTH=8); expected results are queued
// as bits are driven and checked against each done pulse.
module tb_comp_serial_msb;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic bit_vld;
    logic a_bit;
    logic b_bit;
    logic busy;
    logic done;
    logic agb;
    logic alb;
    logic aeb;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [2:0] exp_res_q[$];
    int         exp_cyc_q[$];
    logic [2:0] er;
    int         ec;

    comp_serial_msb #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bit_vld (bit_vld),
        .a_bit   (a_bit),
        .b_bit   (b_bit),
        .busy    (busy),
        .done    (done),
        .agb     (agb),
        .alb     (alb),
        .aeb     (aeb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [2:0] ref_rel(input logic [7:0] a, input logic [7:0] b);
        if (a > b) return 3'b100;
        if (a < b) return 3'b010;
        return 3'b001;
    endfunction

    // Every done pulse is matched against the oldest queued expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            total++;
            if (exp_res_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_done: done=1 at cycle %0d, required no pending result", cyc);
            end else begin
                er = exp_res_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if ({agb, alb, aeb} !== er) begin
                    bad++;
                    $display("[TB] FAIL result: agb/alb/aeb=%b required %b", {agb, alb, aeb}, er);
                end
                total++;
                if (cyc != ec) begin
                    bad++;
                    $display("[TB] FAIL done_latency: done at cycle %0d required %0d", cyc, ec);
                end
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL busy_at_done: busy=%b required 0", busy);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start   = 1'b1;
        bit_vld = 1'b0;
    endtask

    // Drives the first nbits of a word, gap idle cycles after each bit
    task automatic drive_word(input logic [7:0] a, input logic [7:0] b, input int gap, input int nbits);
        int fin;
        fin = WIDTH - 1;
`ifdef COMP_SERIAL_EARLY_EXIT_EN
        for (int i = WIDTH - 1; i >= 0; i--)
            if (a[WIDTH-1-i] != b[WIDTH-1-i]) fin = i;
`endif
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            start   = 1'b0;
            bit_vld = 1'b1;
            a_bit   = a[WIDTH-1-i];
            b_bit   = b[WIDTH-1-i];
            if (i == fin) begin
                exp_res_q.push_back(ref_rel(a, b));
                exp_cyc_q.push_back(cyc + 1);
            end
            repeat (gap) begin
                @(negedge clk);
                bit_vld = 1'b0;
            end
        end
        @(negedge clk);
        start   = 1'b0;
        bit_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bit_vld = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy, done, agb, alb, aeb} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_state: busy/done/agb/alb/aeb=%b required 00000", {busy, done, agb, alb, aeb});
        end
        repeat (2) begin
            @(negedge clk);
            bit_vld = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
        end
        @(negedge clk);
        bit_vld = 1'b0;
        total++;
        if ({busy, agb, alb, aeb} !== 4'b0) begin
            bad++;
            $display("[TB] FAIL idle_ignore: busy/agb/alb/aeb=%b required 0000", {busy, agb, alb, aeb});
        end
    endtask

    task automatic test_equal();
        pulse_start();
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL busy_after_start: busy=%b required 1", busy);
        end
        drive_word(8'hA5, 8'hA5, 0, 8);
        @(negedge clk);
        total++;
        if ({done, agb, alb, aeb} !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL equal_hold: done/agb/alb/aeb=%b required 0001", {done, agb, alb, aeb});
        end
        repeat (2) @(negedge clk);
        total++;
        if (exp_res_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL equal_drain: pending=%0d required 0", exp_res_q.size());
        end
    endtask

    task automatic test_msb_diff();
        pulse_start();
        drive_word(8'h80, 8'h7F, 0, 8);
        repeat (3) @(negedge clk);
        total++;
        if (exp_res_q.size() != 0 || {agb, alb, aeb} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL msb_diff: pending=%0d agb/alb/aeb=%b required 0 100", exp_res_q.size(), {agb, alb, aeb});
        end
    endtask

    task automatic test_lsb_bubbles();
        pulse_start();
        drive_word(8'h3C, 8'h3D, 2, 8);
        repeat (3) @(negedge clk);
        total++;
        if (exp_res_q.size() != 0 || {agb, alb, aeb} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL lsb_bubbles: pending=%0d agb/alb/aeb=%b required 0 010", exp_res_q.size(), {agb, alb, aeb});
        end
    endtask

    task automatic test_abort();
        pulse_start();
        drive_word(8'hFF, 8'h00, 0, 3);
        pulse_start();
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({busy, agb, alb, aeb} !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL abort_clear: busy/agb/alb/aeb=%b required 1000", {busy, agb, alb, aeb});
        end
        drive_word(8'h01, 8'h00, 0, 8);
        repeat (3) @(negedge clk);
        total++;
        if (exp_res_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL abort_drain: pending=%0d required 0", exp_res_q.size());
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        start = 1'b1; bit_vld = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
        drive_word(8'h00, 8'h01, 0, 8);
        repeat (3) @(negedge clk);
        total++;
        if (exp_res_q.size() != 0 || {agb, alb, aeb} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL collision: pending=%0d agb/alb/aeb=%b required 0 010", exp_res_q.size(), {agb, alb, aeb});
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        drive_word(8'h10, 8'h20, 0, 3);
        rst = 1'b1; bit_vld = 1'b1; a_bit = 1'b0; b_bit = 1'b0;
        @(negedge clk);
        rst = 1'b0; bit_vld = 1'b0;
        total++;
        if ({busy, done, agb, alb, aeb} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid: busy/done/agb/alb/aeb=%b required 00000", {busy, done, agb, alb, aeb});
        end
        repeat (8) begin
            @(negedge clk);
            bit_vld = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
        end
        @(negedge clk);
        bit_vld = 1'b0;
        total++;
        if ({busy, agb, alb, aeb} !== 4'b0 || exp_res_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL reset_ignore: busy/agb/alb/aeb=%b pending=%0d required 0000 0", {busy, agb, alb, aeb}, exp_res_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_msb_diff();
        test_lsb_bubbles();
        test_abort();
        test_collision();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
